// File: rtl/mem_line_arbiter.sv
// Line-miss arbiter between I-cache and D-cache: grants one port, models main-memory
// latency, then bursts one line to or from a synchronous word RAM.
module mem_line_arbiter #(
    parameter int DELAY_CYCLES   = 10,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 16
) (
    input  logic                          MEM_CLK,
    input  logic                          RST,
    input  logic                          ic_req,
    input  logic [ADDR_W-5:0]             ic_addr,
    output logic [32*WORDS_PER_LINE-1:0]  ic_line,
    output logic                          ic_valid,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-5:0]             dc_addr,
    input  logic [32*WORDS_PER_LINE-1:0]  dc_wline,
    output logic [32*WORDS_PER_LINE-1:0]  dc_rline,
    output logic                          dc_valid,
    output logic [ADDR_W-3:0]             mm_addr,
    output logic                          mm_we,
    output logic [31:0]                   mm_din,
    input  logic [31:0]                   mm_dout
);
    localparam int LW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int BW = LW + 1;
    localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

    state_t                           r_state, w_next;
    logic                             r_port_d, r_we, r_last_d;
    logic [ADDR_W-5:0]                r_addr;
    logic [CW-1:0]                    r_cnt;
    logic [BW-1:0]                    r_beat;
    logic [WORDS_PER_LINE-1:0][31:0]  r_wbuf, r_rbuf, w_fill;
    logic [32*WORDS_PER_LINE-1:0]     r_ic_line, r_dc_rline;
    logic                             w_any, w_grant_d, w_wait_end, w_burst_end;
    logic [LW-1:0]                    w_word, w_cap;

    // On a tie the port that was not served last wins; r_last_d resets to I so D wins first.
    assign w_any       = ic_req | dc_req;
    assign w_grant_d   = dc_req & (~ic_req | ~r_last_d);
    assign w_wait_end  = (r_cnt == CW'(DELAY_CYCLES - 1));
    assign w_burst_end = r_we ? (r_beat == BW'(WORDS_PER_LINE - 1))
                              : (r_beat == BW'(WORDS_PER_LINE));
    assign w_word      = r_beat[LW-1:0];
    // RAM data lags its address by one cycle, so beat k captures word k-1.
    assign w_cap       = w_word - LW'(1);
    assign ic_line     = r_ic_line;
    assign dc_rline    = r_dc_rline;

    always_comb begin
        w_fill = r_rbuf;
        w_fill[WORDS_PER_LINE-1] = mm_dout;
    end

    always_ff @(posedge MEM_CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = (DELAY_CYCLES == 0) ? S_BURST : S_WAIT;
            S_WAIT:  if (w_wait_end) w_next = S_BURST;
            S_BURST: if (w_burst_end) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge MEM_CLK) begin
        if (RST) begin
            r_port_d   <= 1'b0;
            r_we       <= 1'b0;
            r_last_d   <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_beat     <= '0;
            r_wbuf     <= '0;
            r_rbuf     <= '0;
            r_ic_line  <= '0;
            r_dc_rline <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_port_d <= w_grant_d;
                    r_we     <= w_grant_d & dc_we;
                    r_addr   <= w_grant_d ? dc_addr : ic_addr;
                    if (w_grant_d & dc_we) r_wbuf <= dc_wline;
                    r_cnt    <= '0;
                    r_beat   <= '0;
                end
                S_WAIT: r_cnt <= r_cnt + CW'(1);
                S_BURST: begin
                    r_beat <= r_beat + BW'(1);
                    if (!r_we && r_beat != '0) r_rbuf[w_cap] <= mm_dout;
                    if (!r_we && w_burst_end) begin
                        if (r_port_d) r_dc_rline <= w_fill;
                        else          r_ic_line  <= w_fill;
                    end
                end
                S_DONE: r_last_d <= r_port_d;
                default: ;
            endcase
        end
    end

    // RST gates the strobes combinationally so an aborted burst stops writing at once.
    always_comb begin
        mm_addr  = '0;
        mm_we    = 1'b0;
        mm_din   = '0;
        ic_valid = 1'b0;
        dc_valid = 1'b0;
        case (r_state)
            S_BURST: begin
                mm_addr = {r_addr, w_word};
                if (r_we) begin
                    mm_we  = ~RST;
                    mm_din = r_wbuf[w_word];
                end
            end
            S_DONE: begin
                ic_valid = ~r_port_d & ~RST;
                dc_valid = r_port_d & ~RST;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Sits directly downstream of the I-cache and D-cache inside Memory and services their line misses against the single backing word RAM.
- Arbitrates between an I-cache line-fill port (read only) and a D-cache port (line fill or dirty-line writeback).
- Models main-memory access latency with a programmable delay, then bursts one 4-word line to or from a synchronous word RAM.
- Returns a one-cycle completion pulse to the granted port.

Parameters:
- DELAY_CYCLES, 10, idle cycles inserted between grant and first RAM beat (>= 0).
- WORDS_PER_LINE, 4, words per cache line (power of two).
- ADDR_W, 16, byte-address width.

Ports:
- MEM_CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ic_req  in  1  I-cache line-fill request; held high until ic_valid.
- ic_addr  in  ADDR_W-4  I-cache line address (byte address [ADDR_W-1:4]).
- ic_line  out  32*WORDS_PER_LINE  filled line; word k occupies bits [32k+31:32k].
- ic_valid  out  1  one-cycle pulse; ic_line is valid this cycle.
- dc_req  in  1  D-cache request; held high until dc_valid.
- dc_we  in  1  1 = writeback dc_wline, 0 = line fill.
- dc_addr  in  ADDR_W-4  D-cache line address.
- dc_wline  in  32*WORDS_PER_LINE  writeback data.
- dc_rline  out  32*WORDS_PER_LINE  filled line.
- dc_valid  out  1  one-cycle completion pulse for read or write.
- mm_addr  out  ADDR_W-2  word address to the backing RAM.
- mm_we  out  1  word write enable.
- mm_din  out  32  write data.
- mm_dout  in  32  RAM read data; registered, valid one cycle after mm_addr.

Behaviour:
- States: IDLE, WAIT, BURST, DONE.
- Reset values: state IDLE; ic_valid, dc_valid, mm_we = 0; mm_addr, mm_din, ic_line, dc_rline = 0; last_grant = I. mm_we is forced to 0 in any cycle where RST is high.
- IDLE, grant on edge E0:
  - Only ic_req high: grant I.
  - Only dc_req high: grant D.
  - Both high: grant the port not granted last. After reset, D wins the first tie.
  - At grant, latch port ID, line address, direction and (for writes) dc_wline. Requesters may change their inputs after grant without effect.
  - Go to WAIT with counter = 0, or directly to BURST if DELAY_CYCLES = 0.
- WAIT: counter increments each cycle. After DELAY_CYCLES cycles (edge E0+DELAY_CYCLES), go to BURST with beat = 0. Both request inputs are ignored.
- BURST, write:
  - mm_addr = {line_addr, beat}; mm_we = 1; mm_din = latched word[beat].
  - One beat per cycle, WORDS_PER_LINE cycles.
  - After the last beat, go to DONE at edge E0+DELAY_CYCLES+WORDS_PER_LINE.
- BURST, read:
  - Issue addresses beat 0..WORDS_PER_LINE-1 on consecutive cycles.
  - Capture mm_dout into word[k] one cycle after its address, so the burst takes WORDS_PER_LINE+1 cycles.
  - Go to DONE at edge E0+DELAY_CYCLES+WORDS_PER_LINE+1.
- DONE (one cycle):
  - Assert the granted port's valid, with its line output driven.
  - Line outputs hold their value until the next completion for that port.
  - Update last_grant, then return to IDLE.
  - Request inputs are ignored in DONE; requesters drop req in the cycle after sampling valid.
- Latency with defaults: read valid is high in the cycle after edge E0+15; write valid in the cycle after edge E0+14.
- Non-granted port: its request stays pending and is considered at the next IDLE cycle.
- Reset mid-operation: abort immediately to IDLE. No valid pulse is produced, no further RAM writes occur, and any partially written line stays partially written.
- Address arithmetic: beat wraps within the line and never carries into line_addr.

Test Plan:
1. After reset, ic_req=1, ic_addr=0x001, RAM words 4..7 = 0xA0..0xA3 -> ic_valid in the 16th cycle after grant, ic_line = {0xA3,0xA2,0xA1,0xA0}, single-cycle pulse, mm_we never 1.
2. dc_req=1, dc_we=1, dc_addr=0x600, dc_wline = {4,3,2,1} -> RAM words 0x1800..0x1803 = 1,2,3,4; dc_valid in the 15th cycle after grant; then a fill of 0x600 returns {4,3,2,1}.
3. ic_req and dc_req rise in the same cycle after reset -> D served first, I granted in the IDLE cycle following dc_valid. Repeating the tie -> I served first (alternation).
4. Continuous requests on both ports for 20 transactions -> grants alternate strictly; no port waits more than one transaction.
5. RST pulsed during BURST of a writeback after beat 1 -> words 0 and 1 written, words 2 and 3 unchanged, no dc_valid, state IDLE; a subsequent request completes normally.
6. DELAY_CYCLES=0 build: read valid in the cycle after edge E0+5, write valid in the cycle after edge E0+4.
